x86_alu_unit: RTL and testbench
===============================

Name: x86_alu_unit

Overview:
- Registered integer ALU for the x86-64 core.
- Executes the eight classic two-operand arithmetic/logic opcode families (ADD, OR, ADC, SBB, AND, SUB, XOR, CMP; opcodes 0x00–0x3D), selected directly by the primary opcode byte from the decoder.
- Produces the result, the six status flags and a writeback enable one cycle after issue, for the execute stage.

Parameters:
- XLEN, 64, datapath width in bits; only 64 is supported.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous reset, active-low (asserted when 0)
- in_valid  in  1  operation issue strobe
- opcode  in  8  x86 primary opcode byte
- opsize  in  2  operand size for non-byte forms: 01=16, 10=32, 11=64; 00 treated as 32
- oper1  in  64  destination/first operand (full 64-bit register value)
- oper2  in  64  source/second operand (register, memory or sign-extended immediate)
- flags_in  in  6  current flags {OF,SF,ZF,AF,PF,CF}
- out_valid  out  1  result valid
- alu_res  out  64  result
- flags_out  out  6  updated flags {OF,SF,ZF,AF,PF,CF}
- wr_en  out  1  destination writeback required
- illegal  out  1  opcode not supported

Behaviour:
- All outputs are registered. While reset==0 at a clk edge, every output becomes 0.
- Latency is 1 cycle:
  - in_valid sampled high → out_valid=1 on the next cycle, with results for that issue.
  - in_valid low → out_valid=0. Other outputs hold their last values.
  - Back-to-back issue every cycle is allowed. There is no stall or backpressure.
- Decode:
  - op = opcode[5:3]: 0 ADD, 1 OR, 2 ADC, 3 SBB, 4 AND, 5 SUB, 6 XOR, 7 CMP.
  - Legal only when opcode[7:6]==00 and opcode[2:0] is 0..5.
  - Form = opcode[2:0]: 0, 2 and 4 are byte forms; 1, 3 and 5 are opsize forms.
- Operation width W:
  - Byte forms: W=8.
  - Otherwise W comes from opsize.
  - Computation uses oper1[W-1:0] and oper2[W-1:0].
- Result merge:
  - W=8 or 16: alu_res = {oper1[63:W], r}.
  - W=32: alu_res = {32'b0, r}.
  - W=64: alu_res = r.
- Arithmetic ops:
  - ADC adds flags_in[0] (CF). SBB subtracts it.
  - CF = carry out (ADD/ADC) or borrow out (SUB/SBB/CMP) at bit W.
  - OF = signed overflow at bit W-1.
  - AF = carry/borrow out of bit 3.
- Logic ops (OR, AND, XOR): CF=0, OF=0, AF=0.
- For all legal ops:
  - SF = r[W-1].
  - ZF = (r==0).
  - PF = 1 when r[7:0] has an even number of ones.
- CMP computes SUB flags, then sets wr_en=0 and alu_res=oper1 unchanged. All other legal ops set wr_en=1.
- Illegal opcode:
  - illegal=1, wr_en=0.
  - alu_res=oper1, flags_out=flags_in.
  - out_valid still asserts.
- Reset mid-operation: an issue sampled in the same cycle as reset is dropped. out_valid=0 on the next cycle.

Optional Feature:
- Macro ALU_TEST_EN.
- When defined: opcodes 0x84 (byte form), 0x85 (opsize form), 0xA8 (byte form) and 0xA9 (opsize form) are legal TEST operations.
  - Computation is the AND result and flags.
  - wr_en=0 and alu_res=oper1.
- When undefined: those opcodes follow the illegal-opcode behaviour.

Test Plan:
- Byte SUB: opcode=0x2A, oper1=12, oper2=23, flags_in=0 → next cycle out_valid=1, alu_res=0x00000000000000F5, CF=1, SF=1, ZF=0, OF=0, AF=0, PF=1, wr_en=1.
- 64-bit ADD overflow: opcode=0x01, opsize=11, oper1=0x7FFFFFFFFFFFFFFF, oper2=1 → alu_res=0x8000000000000000, OF=1, SF=1, CF=0, AF=1, PF=1, ZF=0.
- 32-bit ADC with zero-extension: opcode=0x13, opsize=10, oper1=0xAAAAAAAAFFFFFFFF, oper2=0, flags_in CF=1 → alu_res=0, CF=1, ZF=1, AF=1.
- CMP equal: opcode=0x3D, opsize=10, oper1=5, oper2=5 → ZF=1, CF=0, wr_en=0, alu_res=5.
- Illegal opcode and 16-bit merge:
  - opcode=0x0F, flags_in=6'b101010 → illegal=1, wr_en=0, flags_out=6'b101010.
  - Then opcode=0x09, opsize=01, oper1=0x1111222233330000, oper2=0x00FF → alu_res=0x11112222333300FF.
- Reset and throughput:
  - Issue three back-to-back ops → three consecutive out_valid pulses in order.
  - Drive reset=0 alongside a fourth issue → next cycle out_valid=0 and all outputs 0.
  - With ALU_TEST_EN defined, opcode=0x85 on equal operands → ZF=0 for nonzero values and wr_en=0.

Source files
------------

// File: rtl/x86_alu_unit.sv
// ---------------------------------------------------------------------------
// x86_alu_unit
//
// Registered integer ALU for the x86-64 execute stage. It executes the eight
// classic two-operand families (ADD, OR, ADC, SBB, AND, SUB, XOR, CMP) picked
// straight from the primary opcode byte. Result, flags and writeback enable
// appear one cycle after issue.
//
// Optional feature: define ALU_TEST_EN to make opcodes 0x84/0x85/0xA8/0xA9
// legal TEST operations (AND flags, no writeback). Without the macro those
// opcodes are reported as illegal.
//
// Ports:
//   clk        core clock
//   reset      synchronous reset, active-low
//   in_valid   operation issue strobe
//   opcode     x86 primary opcode byte
//   opsize     operand size for non-byte forms (01=16, 10=32, 11=64, 00=32)
//   oper1      destination / first operand
//   oper2      source / second operand
//   flags_in   current flags {OF,SF,ZF,AF,PF,CF}
//   out_valid  result valid, one cycle after in_valid
//   alu_res    merged result
//   flags_out  updated flags {OF,SF,ZF,AF,PF,CF}
//   wr_en      destination writeback required
//   illegal    opcode not supported
// ---------------------------------------------------------------------------
module x86_alu_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [7:0]      opcode,
    input  logic [1:0]      opsize,
    input  logic [XLEN-1:0] oper1,
    input  logic [XLEN-1:0] oper2,
    input  logic [5:0]      flags_in,
    output logic            out_valid,
    output logic [XLEN-1:0] alu_res,
    output logic [5:0]      flags_out,
    output logic            wr_en,
    output logic            illegal
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_OR  = 3'd1,
        OP_ADC = 3'd2,
        OP_SBB = 3'd3,
        OP_AND = 3'd4,
        OP_SUB = 3'd5,
        OP_XOR = 3'd6,
        OP_CMP = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        W8  = 2'd0,
        W16 = 2'd1,
        W32 = 2'd2,
        W64 = 2'd3
    } width_t;

    logic        legal;
    logic        test_hit;
    alu_op_t     eff_op;
    width_t      width;
    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [64:0] raw;
    logic [63:0] r;
    logic        carry;
    logic        sign_a;
    logic        sign_b;
    logic        sign_r;
    logic        arith_sub;
    logic        is_logic;
    logic        zf;
    logic        pf;
    logic        of;
    logic        af;

    logic [63:0] nxt_res;
    logic [5:0]  nxt_flags;
    logic        nxt_wr;
    logic        nxt_ill;

    // Sign bit of a value at the current operation width.
    function automatic logic top_bit(input logic [63:0] v, input width_t w);
        case (w)
            W8:      top_bit = v[7];
            W16:     top_bit = v[15];
            W32:     top_bit = v[31];
            default: top_bit = v[63];
        endcase
    endfunction

`ifdef ALU_TEST_EN
    assign test_hit = (opcode == 8'h84) || (opcode == 8'h85) ||
                      (opcode == 8'hA8) || (opcode == 8'hA9);
`else
    assign test_hit = 1'b0;
`endif

    // Decode: even low opcode bits are byte forms (this also holds for the
    // TEST encodings 0x84/0xA8), odd ones take their width from opsize.
    always_comb begin
        legal  = (opcode[7:6] == 2'b00) && (opcode[2:0] <= 3'd5);
        eff_op = test_hit ? OP_AND : alu_op_t'(opcode[5:3]);
        width  = W32;
        if (!opcode[0]) begin
            width = W8;
        end else begin
            case (opsize)
                2'b01:   width = W16;
                2'b11:   width = W64;
                default: width = W32;
            endcase
        end
        case (width)
            W8:      mask = 64'h0000_0000_0000_00FF;
            W16:     mask = 64'h0000_0000_0000_FFFF;
            W32:     mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Datapath. Operands are masked to the operation width and computed in a
    // 65-bit lane, so the carry/borrow sits at bit W of the raw result for
    // every width (a borrow sign-extends all the way up).
    always_comb begin
        a         = oper1 & mask;
        b         = oper2 & mask;
        cin       = ((eff_op == OP_ADC) || (eff_op == OP_SBB)) ? flags_in[0] : 1'b0;
        arith_sub = (eff_op == OP_SBB) || (eff_op == OP_SUB) || (eff_op == OP_CMP);
        is_logic  = (eff_op == OP_OR) || (eff_op == OP_AND) || (eff_op == OP_XOR);

        case (eff_op)
            OP_OR:   raw = {1'b0, a | b};
            OP_AND:  raw = {1'b0, a & b};
            OP_XOR:  raw = {1'b0, a ^ b};
            OP_ADD,
            OP_ADC:  raw = {1'b0, a} + {1'b0, b} + {64'd0, cin};
            default: raw = {1'b0, a} - {1'b0, b} - {64'd0, cin};
        endcase

        r = raw[63:0] & mask;

        case (width)
            W8:      carry = raw[8];
            W16:     carry = raw[16];
            W32:     carry = raw[32];
            default: carry = raw[64];
        endcase

        sign_a = top_bit(a, width);
        sign_b = top_bit(b, width);
        sign_r = top_bit(r, width);

        // Subtraction overflows only when operand signs differ; addition
        // only when they agree. In both cases the result sign flips from a.
        if (arith_sub) begin
            of = (sign_a != sign_b) && (sign_r != sign_a);
        end else begin
            of = (sign_a == sign_b) && (sign_r != sign_a);
        end

        // Bit 4 of a^b^r is the carry (or borrow) coming out of bit 3.
        af = a[4] ^ b[4] ^ r[4];
        zf = (r == 64'd0);
        pf = ~^r[7:0];
    end

    // Result merge, flag assembly and writeback decision.
    always_comb begin
        nxt_res   = r;
        nxt_flags = {of, sign_r, zf, af, pf, carry};
        nxt_wr    = 1'b1;
        nxt_ill   = 1'b0;

        if (is_logic) begin
            nxt_flags = {1'b0, sign_r, zf, 1'b0, pf, 1'b0};
        end

        // 8/16-bit writes keep the untouched upper bits; 32-bit writes
        // zero-extend, which the masked r already provides.
        if ((width == W8) || (width == W16)) begin
            nxt_res = (oper1 & ~mask) | r;
        end

        if (!legal && !test_hit) begin
            nxt_res   = oper1;
            nxt_flags = flags_in;
            nxt_wr    = 1'b0;
            nxt_ill   = 1'b1;
        end else if ((eff_op == OP_CMP) || test_hit) begin
            nxt_res = oper1;
            nxt_wr  = 1'b0;
        end
    end

    // Output registers. Data outputs only update on an issue so they hold
    // between issues; an issue in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            alu_res   <= '0;
            flags_out <= '0;
            wr_en     <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                alu_res   <= nxt_res;
                flags_out <= nxt_flags;
                wr_en     <= nxt_wr;
                illegal   <= nxt_ill;
            end
        end
    end

endmodule

// File: tb/tb_x86_alu_unit.sv
// ---------------------------------------------------------------------------
// tb_x86_alu_unit
//
// Scoreboard bench for x86_alu_unit. The stimulus side pushes the expected
// response of every accepted issue into a queue using an arithmetic reference
// model; the monitor pops and compares whenever out_valid is seen, checks
// hold behaviour on idle cycles and zeroed outputs after reset.
// ---------------------------------------------------------------------------
module tb_x86_alu_unit;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  flags;
        logic        wr;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [7:0]  opcode;
    logic [1:0]  opsize;
    logic [63:0] oper1;
    logic [63:0] oper2;
    logic [5:0]  flags_in;
    logic        out_valid;
    logic [63:0] alu_res;
    logic [5:0]  flags_out;
    logic        wr_en;
    logic        illegal;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    x86_alu_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .opcode    (opcode),
        .opsize    (opsize),
        .oper1     (oper1),
        .oper2     (oper2),
        .flags_in  (flags_in),
        .out_valid (out_valid),
        .alu_res   (alu_res),
        .flags_out (flags_out),
        .wr_en     (wr_en),
        .illegal   (illegal)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain modular and signed arithmetic on wide integers.
    function automatic exp_t model(input logic [7:0] op8, input logic [1:0] sz,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [5:0] fin);
        exp_t                 e;
        bit                   legal;
        bit                   is_test;
        int                   fam;
        int                   w;
        logic [127:0]         modv;
        logic [127:0]         ua;
        logic [127:0]         ub;
        logic [127:0]         cin;
        logic [127:0]         sum;
        logic [127:0]         r;
        logic [127:0]         merged;
        logic signed [127:0]  sa;
        logic signed [127:0]  sb;
        logic signed [127:0]  ss;
        logic signed [127:0]  smax;
        logic signed [127:0]  smin;
        bit                   cf;
        bit                   of;
        bit                   af;
        bit                   sf;
        bit                   zf;
        bit                   pf;

        legal   = (op8 < 8'h40) && ((op8 % 8) < 6);
        is_test = 1'b0;
`ifdef ALU_TEST_EN
        is_test = (op8 == 8'h84) || (op8 == 8'h85) || (op8 == 8'hA8) || (op8 == 8'hA9);
`endif
        if (!legal && !is_test) begin
            e.res   = a;
            e.flags = fin;
            e.wr    = 1'b0;
            e.ill   = 1'b1;
            return e;
        end

        fam = is_test ? 4 : int'(op8 / 8);
        if ((op8 % 2) == 0)   w = 8;
        else if (sz == 2'b01) w = 16;
        else if (sz == 2'b11) w = 64;
        else                  w = 32;

        modv = 128'd1 << w;
        ua   = {64'd0, a} % modv;
        ub   = {64'd0, b} % modv;
        cin  = ((fam == 2) || (fam == 3)) ? {127'd0, fin[0]} : 128'd0;
        sa   = (ua >= modv / 2) ? $signed(ua - modv) : $signed(ua);
        sb   = (ub >= modv / 2) ? $signed(ub - modv) : $signed(ub);
        smax = $signed(modv / 2) - 1;
        smin = -$signed(modv / 2);
        cf   = 1'b0;
        of   = 1'b0;
        af   = 1'b0;
        r    = 128'd0;

        case (fam)
            0, 2: begin
                sum = ua + ub + cin;
                cf  = (sum >= modv);
                r   = sum % modv;
                ss  = sa + sb + $signed(cin);
                of  = (ss > smax) || (ss < smin);
                af  = ((ua % 16) + (ub % 16) + cin) >= 16;
            end
            3, 5, 7: begin
                cf  = ua < (ub + cin);
                r   = (ua + 2 * modv - ub - cin) % modv;
                ss  = sa - sb - $signed(cin);
                of  = (ss > smax) || (ss < smin);
                af  = (ua % 16) < ((ub % 16) + cin);
            end
            1:       r = ua | ub;
            4:       r = ua & ub;
            default: r = ua ^ ub;
        endcase

        sf = (r >= modv / 2);
        zf = (r == 128'd0);
        pf = ($countones(r[7:0]) % 2) == 0;

        e.flags = {of, sf, zf, af, pf, cf};
        e.ill   = 1'b0;
        if ((fam == 7) || is_test) begin
            e.res = a;
            e.wr  = 1'b0;
        end else begin
            e.wr = 1'b1;
            if (w <= 16) begin
                merged = ({64'd0, a} - ua) + r;
                e.res  = merged[63:0];
            end else begin
                e.res = r[63:0];
            end
        end
        return e;
    endfunction

    // Compares every output against an expectation; one count per field.
    task automatic checkOutput(input string tag, input logic exp_valid, input exp_t e);
        logic [5:0] got_flags;
        logic [63:0] got_res;
        got_flags = flags_out;
        got_res   = alu_res;
        n_vec++;
        if (out_valid !== exp_valid) begin
            n_err++;
            $display("[TB] FAIL %s out_valid: got %0b expected %0b at %0t", tag, out_valid, exp_valid, $time);
        end
        n_vec++;
        if (got_res !== e.res) begin
            n_err++;
            $display("[TB] FAIL %s alu_res: got %h expected %h at %0t", tag, got_res, e.res, $time);
        end
        n_vec++;
        if (got_flags !== e.flags) begin
            n_err++;
            $display("[TB] FAIL %s flags_out: got %b expected %b at %0t", tag, got_flags, e.flags, $time);
        end
        n_vec++;
        if ({wr_en, illegal} !== {e.wr, e.ill}) begin
            n_err++;
            $display("[TB] FAIL %s wr_en/illegal: got %0b/%0b expected %0b/%0b at %0t",
                     tag, wr_en, illegal, e.wr, e.ill, $time);
        end
    endtask

    // Monitor: samples reset at the rising edge, checks outputs at the
    // falling edge. Idle cycles must hold the last issued response.
    initial begin : monitor
        exp_t held;
        exp_t zero_e;
        exp_t e;
        bit   rst_seen;
        held   = '0;
        zero_e = '0;
        forever begin
            @(posedge clk);
            rst_seen = (reset == 1'b0);
            @(negedge clk);
            if (rst_seen) begin
                held = '0;
                checkOutput("reset", 1'b0, zero_e);
            end else if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_valid: got out_valid=1 expected no pending issue at %0t", $time);
                end else begin
                    e    = exp_q.pop_front();
                    held = e;
                    checkOutput("issue", 1'b1, e);
                end
            end else begin
                checkOutput("hold", 1'b0, held);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] op, input logic [1:0] sz,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [5:0] f);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        opcode   = op;
        opsize   = sz;
        oper1    = a;
        oper2    = b;
        flags_in = f;
        exp_q.push_back(model(op, sz, a, b, f));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        oper1    = {$urandom, $urandom};
        oper2    = {$urandom, $urandom};
    endtask

    // Reset asserted together with an issue: the issue must be dropped.
    task automatic resetWithIssue();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b1;
        opcode   = 8'h01;
        opsize   = 2'b11;
        oper1    = 64'h1234_5678_9ABC_DEF0;
        oper2    = 64'h1;
        flags_in = 6'b111111;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] pickOperand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0:       v = 64'd0;
            1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
            2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
            3:       v = 64'h8000_0000_0000_0000;
            4:       v = {$urandom, 24'h0, 8'($urandom_range(0, 255))};
            5:       v = {32'h0, 32'($urandom_range(0, 15))};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    function automatic logic [7:0] pickOpcode();
        logic [7:0] op;
        logic [7:0] rnd;
        rnd = 8'($urandom);
        case ($urandom_range(0, 9))
            0:       op = rnd;
            1: begin
                case ($urandom_range(0, 3))
                    0:       op = 8'h84;
                    1:       op = 8'h85;
                    2:       op = 8'hA8;
                    default: op = 8'hA9;
                endcase
            end
            default: op = {2'b00, rnd[5:0]};
        endcase
        return op;
    endfunction

    initial begin : stimulus
        reset    = 1'b0;
        in_valid = 1'b0;
        opcode   = 8'h00;
        opsize   = 2'b00;
        oper1    = 64'd0;
        oper2    = 64'd0;
        flags_in = 6'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idleCycle();

        // Directed vectors from the intended use cases.
        applyStimulus(8'h2A, 2'b00, 64'd12, 64'd23, 6'b000000);
        applyStimulus(8'h01, 2'b11, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'b000000);
        applyStimulus(8'h13, 2'b10, 64'hAAAA_AAAA_FFFF_FFFF, 64'd0, 6'b000001);
        applyStimulus(8'h3D, 2'b10, 64'd5, 64'd5, 6'b000000);
        applyStimulus(8'h0F, 2'b10, 64'h0123_4567_89AB_CDEF, 64'd7, 6'b101010);
        applyStimulus(8'h09, 2'b01, 64'h1111_2222_3333_0000, 64'h0000_0000_0000_00FF, 6'b000000);
        idleCycle();
        idleCycle();
        applyStimulus(8'h85, 2'b11, 64'h0000_0000_0000_00F0, 64'h0000_0000_0000_00F0, 6'b000000);
        applyStimulus(8'h1A, 2'b00, 64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0000, 6'b000001);
        applyStimulus(8'h39, 2'b00, 64'hFFFF_FFFF_0000_0001, 64'd2, 6'b000000);
        idleCycle();

        // Three back-to-back issues, then reset alongside a fourth.
        applyStimulus(8'h05, 2'b11, 64'd100, 64'd200, 6'b000000);
        applyStimulus(8'h21, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F, 6'b000000);
        applyStimulus(8'h30, 2'b00, 64'hAA, 64'h55, 6'b000000);
        resetWithIssue();
        idleCycle();

        // Randomized traffic with occasional idle cycles and a reset burst.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                resetWithIssue();
            end else if ($urandom_range(0, 3) == 0) begin
                idleCycle();
            end else begin
                applyStimulus(pickOpcode(), 2'($urandom_range(0, 3)), pickOperand(),
                              pickOperand(), 6'($urandom_range(0, 63)));
            end
        end

        idleCycle();
        repeat (3) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("[TB] FAIL drain: got %0d responses outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
